// File: rtl/decode_regfile_sb.sv
// Decode-stage register file with write-through bypass and a one-bit-per-register
// scoreboard that stalls issue on RAW/WAW hazards against in-flight writebacks.
module decode_regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2,
  parameter int ZERO_R0  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_RD-1:0]          rd_used,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       issue_valid,
  input  logic                       issue_wr,
  input  logic [ADDR_W-1:0]          issue_dst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       flush,
  output logic                       stall,
  output logic [NUM_REGS-1:0]        pending
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] dst_hit;
  logic [NUM_REGS-1:0] haz_vec;
  logic [NUM_REGS-1:0] pending_next;
  logic [NUM_RD-1:0]   rd_haz;
  logic                accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // A hardwired r0 is never written, never marked pending and never bypassed.
      localparam bit WRITABLE = !((ZERO_R0 != 0) && (gi == 0));

      assign wr_hit[gi]  = WRITABLE && wr_en && (wr_addr == ADDR_W'(gi));
      assign dst_hit[gi] = WRITABLE && (issue_dst == ADDR_W'(gi));
      // A writeback landing this cycle resolves the hazard it would otherwise cause.
      assign haz_vec[gi] = pending[gi] && !wr_hit[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regs[gi] <= '0;
        end else if (wr_hit[gi]) begin
          regs[gi] <= wr_data;
        end
      end
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              haz;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      // Addresses beyond NUM_REGS match no entry and therefore read as zero.
      always_comb begin
        data = '0;
        haz  = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
          if (addr == ADDR_W'(r)) begin
            data = wr_hit[r] ? wr_data : regs[r];
            haz  = haz_vec[r];
          end
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data;
      assign rd_haz[gi] = haz && rd_used[gi];
    end
  endgenerate

  assign stall  = issue_valid && !flush &&
                  ((|rd_haz) || (issue_wr && (|(dst_hit & haz_vec))));
  assign accept = issue_valid && !flush && !stall;

  // Issue is applied after the writeback clear so a same-edge re-issue keeps the bit set.
  always_comb begin
    if (flush) begin
      pending_next = '0;
    end else begin
      pending_next = (pending & ~wr_hit) | ({NUM_REGS{accept && issue_wr}} & dst_hit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

endmodule

// File: doc/decode_regfile_sb.md
DECODE_REGFILE_SB -- requirements
Module: decode_regfile_sb

Interface
REQ-001 Parameter DATA_W, default 16, register data width in bits.
REQ-002 Parameter NUM_REGS, default 8, number of architectural registers.
REQ-003 Parameter ADDR_W, default 3, register address width; SHALL satisfy 2**ADDR_W >= NUM_REGS.
REQ-004 Parameter NUM_RD, default 2, number of read ports (source operands per instruction).
REQ-005 Parameter ZERO_R0, default 0; when 1, register 0 is hardwired to zero.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 rd_used  in  NUM_RD  port i source is actually consumed by the decoding instruction.
REQ-010 rd_data  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-011 issue_valid  in  1  decode stage presents an instruction this cycle.
REQ-012 issue_wr  in  1  presented instruction writes a destination register.
REQ-013 issue_dst  in  ADDR_W  destination register of presented instruction.
REQ-014 wr_en  in  1  writeback-stage write strobe.
REQ-015 wr_addr  in  ADDR_W  writeback register address.
REQ-016 wr_data  in  DATA_W  writeback data.
REQ-017 flush  in  1  squash all in-flight instructions (branch/jump taken).
REQ-018 stall  out  1  decode must hold; presented instruction not accepted.
REQ-019 pending  out  NUM_REGS  scoreboard: bit r set = register r awaits writeback.

Function
REQ-020 Register array and pending bits SHALL update only on rising clk edge, except under rst.
REQ-021 Write: wr_en=1 and wr_addr<NUM_REGS SHALL store wr_data into reg[wr_addr] and clear pending[wr_addr] at the edge.
REQ-022 wr_addr >= NUM_REGS SHALL be ignored (no state change).
REQ-023 Read: rd_data port i SHALL be combinational: wr_data when wr_en=1 and wr_addr==rd_addr[i] (write-through bypass), else reg[rd_addr[i]]; 0 when rd_addr[i] >= NUM_REGS.
REQ-024 Hazard on address a: pending[a]=1 and not (wr_en=1 and wr_addr==a).
REQ-025 stall SHALL be combinational: issue_valid=1 and flush=0 and (any port i with rd_used[i]=1 and hazard on rd_addr[i], or issue_wr=1 and hazard on issue_dst); else 0.
REQ-026 Issue accepted when issue_valid=1, stall=0, flush=0; if also issue_wr=1, pending[issue_dst] SHALL be set at the edge.
REQ-027 Same-edge write and accepted issue to same register: data written, pending ends SET (issue wins).
REQ-028 flush=1 SHALL clear all pending bits at the edge, suppress issue, force stall=0; a concurrent wr_en write still commits to the array.
REQ-029 ZERO_R0=1: reads of reg 0 return 0 (including bypass), writes to reg 0 ignored, pending[0] never set, reg 0 never causes hazard.
REQ-030 At most one pending write per register; WAW is resolved by stall (REQ-025), no counters.
REQ-031 pending output SHALL equal the internal scoreboard register (registered, no combinational path).

Reset
REQ-032 rst=1 SHALL immediately clear all registers to 0 and all pending bits to 0, independent of clk.
REQ-033 During rst=1, rd_data SHALL read 0 (bypass still applies if wr_en=1) and stall SHALL be 0 unless a bypass-independent hazard exists (none, pending=0).
REQ-034 rst asserted mid-operation SHALL discard all in-flight pending state; first edge after release behaves as from power-up.

Verification
REQ-035 Reset then read all regs -> rd_data=0, pending=0, stall=0.
REQ-036 wr_en=1, wr_addr=3, wr_data=16'h1234, rd_addr port0=3 same cycle -> rd_data port0=16'h1234 combinationally; next cycle reg[3] reads 16'h1234.
REQ-037 Issue issue_wr=1 dst=5; next cycle present rd_addr port1=5 with rd_used=2'b10 -> stall=1 until cycle wr_en=1 wr_addr=5 wr_data=16'h00AB, where stall=0 and rd_data port1=16'h00AB; pending[5] cleared after edge.
REQ-038 pending[2]=1, issue_dst=2 issue_wr=1 -> stall=1 (WAW); same with rd_used=0 on a port reading 2 and issue_wr=0 -> stall=0.
REQ-039 pending=8'b0010_0110, flush=1 with issue_valid=1 dst=7 and wr_en=1 wr_addr=1 wr_data=16'hBEEF -> stall=0, after edge pending=0, reg[1]=16'hBEEF, pending[7]=0.
REQ-040 ZERO_R0=1, NUM_RD=3, DATA_W=32: write 32'hFFFF_FFFF to reg 0, issue dst=0 -> reads 0, pending[0]=0, stall=0; rst pulse mid-stall clears pending asynchronously.
